reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter data_width, 16, width of entry value and CDB data.
REQ-002 Parameter tag_width, 3, ROB index width; depth = 2**tag_width (8).
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port rob_write_enable, input, 1: issue allocates the tail entry this cycle.
REQ-006 Port rob_opcode, input, lc3b_opcode: opcode of the issued instruction.
REQ-007 Port rob_dest, input, 3: architectural destination register.
REQ-008 Port rob_value_in, input, data_width: initial value; for BR, the recovery PC.
REQ-009 Port rob_addr, output, tag_width: current tail index, which is the entry the next write allocates.
REQ-010 Port rob_full, output, 1: all entries busy.
REQ-011 Port CDB_in, input, CDB: valid/tag/data broadcast from the functional units.
REQ-012 Port rob_sr1_read_addr and rob_sr2_read_addr, input, tag_width: operand lookup indices.
REQ-013 Port rob_sr1_value_out and rob_sr2_value_out, output, data_width: entry value at the read index.
REQ-014 Port rob_sr1_valid_out and rob_sr2_valid_out, output, 1: the entry is busy and ready.
REQ-015 Port commit_ld_reg, output, 1: write regfile this cycle.
REQ-016 Port commit_dest, output, 3: regfile destination register.
REQ-017 Port commit_value, output, data_width: regfile write data.
REQ-018 Port commit_rob_entry, output, tag_width: head index; the regfile clears busy only if its rob_entry matches.
REQ-019 Port flush, output, 1: mispredicted branch retired.
REQ-020 Port flush_pc, output, 16: redirect PC, valid only when flush=1.

Function
REQ-021 Per-entry state SHALL be: busy, ready, mispredict, opcode, dest, value.
REQ-022 Pointers SHALL be head, tail, and count (0..depth). rob_full SHALL equal (count == depth).
REQ-023 Write with !rob_full SHALL set entry[tail] as follows:
- busy=1, opcode/dest/value from the inputs, mispredict=0.
- ready=1 for op_lea, ready=0 for all other opcodes.
- tail SHALL increment modulo depth.
REQ-024 Write with rob_full=1 SHALL be ignored, with no state change.
REQ-025 CDB_in.valid with a busy entry at CDB_in.tag SHALL set ready=1 on that entry:
- non-BR entry: value SHALL be set to CDB data.
- BR entry: value SHALL be left unchanged and mispredict SHALL be set to data[0].
REQ-026 CDB_in.valid with a tag that is not busy SHALL be ignored.
REQ-027 Commit SHALL occur when entry[head] is busy and ready.
- Commit SHALL clear busy and advance head.
- At most one commit per cycle.
- An entry readied by the CDB SHALL commit no earlier than the following cycle.
REQ-028 Commit of a non-BR entry SHALL drive, combinationally in the commit cycle:
- commit_ld_reg=1.
- commit_dest=dest, commit_value=value, commit_rob_entry=head.
REQ-029 Commit of a BR entry SHALL drive commit_ld_reg=0.
- If mispredict=1: flush=1 and flush_pc=value for that same cycle.
REQ-030 A flush SHALL, on the next edge:
- clear all busy and ready bits;
- set head=tail=count=0;
- drop any same-cycle write and CDB update.
REQ-031 Simultaneous write and commit without flush SHALL leave count unchanged; pointer wrap from depth-1 to 0 SHALL be seamless.
REQ-032 Read ports SHALL be combinational: value_out=entry.value, valid_out=busy&ready.
REQ-033 Outputs when idle: commit_*=0, flush=0, flush_pc=0.

Reset
REQ-034 reset_n=0 SHALL asynchronously clear all entry state, head, tail, and count.
- rob_addr=0, rob_full=0, flush=0, commit_ld_reg=0, all value outputs 0.
REQ-035 Reset mid-operation SHALL discard all in-flight entries without commit or flush.

Configuration
REQ-036 Macro ROB_READ_BYPASS_EN.
- Defined: a read port whose index equals a valid CDB tag on a busy entry SHALL return CDB data with valid=1 in the same cycle.
- Undefined: read ports reflect registered state only.

Structure
REQ-037 The rob_entry_t typedef SHALL be added to lc3b_types; the package already provides lc3b_rob_addr, the CDB struct, and lc3b_opcode.
REQ-038 No sub-module is required; the entry array SHALL be held in a single always_ff block.

Verification
REQ-039 Reset, then 8 writes of op_add (dest 1..8 mod 8):
- After the 8th write: rob_full=1 and rob_addr=0.
- A 9th write SHALL be ignored.
REQ-040 Write op_add dest=3 at entry 0, then CDB{1,0,x1234}:
- Next cycle: commit_ld_reg=1, commit_dest=3, commit_value=x1234, commit_rob_entry=0.
REQ-041 op_lea dest=2 value=x3000 written to an empty ROB:
- Commits the cycle after the write with commit_value=x3000.
REQ-042 BR with value x0040, then op_add, then CDB for the BR with data=x0001:
- At BR commit: flush=1 and flush_pc=x0040.
- Next cycle: count=0 and rob_addr=0.
- The op_add never commits.
REQ-043 Entries 0 and 1 busy, CDB tag 1 arrives before tag 0:
- No commit until tag 0 readies.
- Then entries 0 and 1 commit on consecutive cycles.
REQ-044 ROB_READ_BYPASS_EN defined, entry 5 pending, CDB{1,5,xBEEF}, rob_sr1_read_addr=5:
- Same cycle: rob_sr1_valid_out=1 and rob_sr1_value_out=xBEEF.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the out-of-order core: datapath words, opcodes,
// the common data bus (CDB) broadcast, and the reorder-buffer entry.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [2:0]  lc3b_rob_addr;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  // Result broadcast from the functional units.
  typedef struct packed {
    logic         valid;
    lc3b_rob_addr tag;
    lc3b_word     data;
  } lc3b_cdb;

  // One in-flight instruction. For branches, value holds the recovery PC
  // and mispredict is filled in by the branch unit via the CDB.
  typedef struct packed {
    logic       busy;
    logic       ready;
    logic       mispredict;
    lc3b_opcode opcode;
    lc3b_reg    dest;
    lc3b_word   value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at the tail on issue, captures results
// from the CDB, retires in order from the head, and flushes everything when
// a mispredicted branch retires.
// Optional macro ROB_READ_BYPASS_EN: operand read ports forward a same-cycle
// CDB result for a busy entry; otherwise they show registered state only.
module reorder_buffer
  import lc3b_types::*;
#(
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rob_write_enable,
  input  lc3b_opcode            rob_opcode,
  input  logic [2:0]            rob_dest,
  input  logic [data_width-1:0] rob_value_in,
  output logic [tag_width-1:0]  rob_addr,
  output logic                  rob_full,
  input  lc3b_cdb               CDB_in,
  input  logic [tag_width-1:0]  rob_sr1_read_addr,
  input  logic [tag_width-1:0]  rob_sr2_read_addr,
  output logic [data_width-1:0] rob_sr1_value_out,
  output logic [data_width-1:0] rob_sr2_value_out,
  output logic                  rob_sr1_valid_out,
  output logic                  rob_sr2_valid_out,
  output logic                  commit_ld_reg,
  output logic [2:0]            commit_dest,
  output logic [data_width-1:0] commit_value,
  output logic [tag_width-1:0]  commit_rob_entry,
  output logic                  flush,
  output logic [15:0]           flush_pc
);

  localparam int depth = 2 ** tag_width;

  rob_entry_t entries [depth];
  logic [tag_width-1:0] head;
  logic [tag_width-1:0] tail;
  logic [tag_width:0]   count;
  logic [tag_width:0]   count_next;

  rob_entry_t head_entry;
  logic       do_commit;
  logic       do_write;
  logic       cdb_hit;

  assign head_entry = entries[head];
  assign do_commit  = head_entry.busy & head_entry.ready;
  assign rob_full   = (count == (tag_width + 1)'(depth));
  assign do_write   = rob_write_enable & ~rob_full;
  assign cdb_hit    = CDB_in.valid & entries[CDB_in.tag].busy;
  assign rob_addr   = tail;

  // Occupancy bookkeeping: a simultaneous allocate and retire cancel out.
  always_comb begin
    count_next = count;
    if (do_write && !do_commit) begin
      count_next = count + (tag_width + 1)'(1);
    end else if (!do_write && do_commit) begin
      count_next = count - (tag_width + 1)'(1);
    end
  end

  // Retire port: drive regfile write or branch redirect from the head entry.
  always_comb begin
    commit_ld_reg    = 1'b0;
    commit_dest      = '0;
    commit_value     = '0;
    commit_rob_entry = '0;
    flush            = 1'b0;
    flush_pc         = '0;
    if (do_commit) begin
      if (head_entry.opcode == op_br) begin
        if (head_entry.mispredict) begin
          flush    = 1'b1;
          flush_pc = head_entry.value;
        end
      end else begin
        commit_ld_reg    = 1'b1;
        commit_dest      = head_entry.dest;
        commit_value     = head_entry.value;
        commit_rob_entry = head;
      end
    end
  end

  // Operand read port 1, optionally forwarding a same-cycle CDB result.
  always_comb begin
    rob_sr1_value_out = entries[rob_sr1_read_addr].value;
    rob_sr1_valid_out = entries[rob_sr1_read_addr].busy & entries[rob_sr1_read_addr].ready;
`ifdef ROB_READ_BYPASS_EN
    if (cdb_hit && (CDB_in.tag == rob_sr1_read_addr)) begin
      rob_sr1_value_out = CDB_in.data;
      rob_sr1_valid_out = 1'b1;
    end
`endif
  end

  // Operand read port 2, optionally forwarding a same-cycle CDB result.
  always_comb begin
    rob_sr2_value_out = entries[rob_sr2_read_addr].value;
    rob_sr2_valid_out = entries[rob_sr2_read_addr].busy & entries[rob_sr2_read_addr].ready;
`ifdef ROB_READ_BYPASS_EN
    if (cdb_hit && (CDB_in.tag == rob_sr2_read_addr)) begin
      rob_sr2_value_out = CDB_in.data;
      rob_sr2_valid_out = 1'b1;
    end
`endif
  end

  // Entry array and pointers. A retiring mispredict overrides every other
  // update this cycle. The CDB only targets busy entries and allocation only
  // targets a free one, so those two never collide; retire is written last
  // so it wins if a stale CDB repeat lands on the retiring head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < depth; i++) begin
        entries[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      for (int i = 0; i < depth; i++) begin
        entries[i].busy  <= 1'b0;
        entries[i].ready <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (cdb_hit) begin
        entries[CDB_in.tag].ready <= 1'b1;
        if (entries[CDB_in.tag].opcode == op_br) begin
          entries[CDB_in.tag].mispredict <= CDB_in.data[0];
        end else begin
          entries[CDB_in.tag].value <= CDB_in.data;
        end
      end
      if (do_commit) begin
        entries[head].busy  <= 1'b0;
        entries[head].ready <= 1'b0;
        head <= head + tag_width'(1);
      end
      if (do_write) begin
        entries[tail].busy       <= 1'b1;
        entries[tail].ready      <= (rob_opcode == op_lea);
        entries[tail].mispredict <= 1'b0;
        entries[tail].opcode     <= rob_opcode;
        entries[tail].dest       <= rob_dest;
        entries[tail].value      <= rob_value_in;
        tail <= tail + tag_width'(1);
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a directed vector table, hand
// sequences for fill/overflow and read bypass, then randomized traffic
// checked against a queue-based model of in-order retirement.
module tb_reorder_buffer;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rob_write_enable;
  lc3b_opcode  rob_opcode;
  logic [2:0]  rob_dest;
  logic [15:0] rob_value_in;
  logic [2:0]  rob_addr;
  logic        rob_full;
  lc3b_cdb     cdb;
  logic [2:0]  sr1_addr, sr2_addr;
  logic [15:0] sr1_value, sr2_value;
  logic        sr1_valid, sr2_valid;
  logic        commit_ld_reg;
  logic [2:0]  commit_dest;
  logic [15:0] commit_value;
  logic [2:0]  commit_rob_entry;
  logic        flush;
  logic [15:0] flush_pc;

  reorder_buffer #(.data_width(16), .tag_width(3)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rob_write_enable  (rob_write_enable),
    .rob_opcode        (rob_opcode),
    .rob_dest          (rob_dest),
    .rob_value_in      (rob_value_in),
    .rob_addr          (rob_addr),
    .rob_full          (rob_full),
    .CDB_in            (cdb),
    .rob_sr1_read_addr (sr1_addr),
    .rob_sr2_read_addr (sr2_addr),
    .rob_sr1_value_out (sr1_value),
    .rob_sr2_value_out (sr2_value),
    .rob_sr1_valid_out (sr1_valid),
    .rob_sr2_valid_out (sr2_valid),
    .commit_ld_reg     (commit_ld_reg),
    .commit_dest       (commit_dest),
    .commit_value      (commit_value),
    .commit_rob_entry  (commit_rob_entry),
    .flush             (flush),
    .flush_pc          (flush_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input lc3b_opcode op, input logic [2:0] d,
                       input logic [15:0] v, input logic cv, input logic [2:0] ct,
                       input logic [15:0] cd);
    rob_write_enable = we;
    rob_opcode       = op;
    rob_dest         = d;
    rob_value_in     = v;
    cdb.valid        = cv;
    cdb.tag          = ct;
    cdb.data         = cd;
  endtask

  // Apply inputs on the falling edge; outputs are then checked 1 ns later.
  task automatic step(input logic we, input lc3b_opcode op, input logic [2:0] d,
                      input logic [15:0] v, input logic cv, input logic [2:0] ct,
                      input logic [15:0] cd);
    @(negedge clk);
    drive(we, op, d, v, cv, ct, cd);
    #1;
  endtask

  // ---------------- reference model: queue of in-flight instructions ----
  typedef struct {
    int          tag;
    lc3b_opcode  op;
    logic [2:0]  dest;
    logic [15:0] val;
    bit          rdy;
    bit          misp;
  } ment_t;

  ment_t q[$];
  int    m_head = 0;

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, op_add, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    sr1_addr = 3'd0;
    sr2_addr = 3'd0;
    reset_n  = 1'b0;
    #1;
    check("rst_addr",   32'(rob_addr), 32'd0);
    check("rst_full",   32'(rob_full), 32'd0);
    check("rst_ld",     32'(commit_ld_reg), 32'd0);
    check("rst_flush",  32'(flush), 32'd0);
    check("rst_fpc",    32'(flush_pc), 32'd0);
    check("rst_cval",   32'(commit_value), 32'd0);
    check("rst_sr1v",   32'(sr1_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    m_head = 0;
  endtask

  task automatic exp_read(input logic [2:0] a, output bit v, output logic [15:0] val);
    v   = 1'b0;
    val = 16'h0;
    foreach (q[k]) begin
      if (q[k].tag == int'(a)) begin
        v   = q[k].rdy;
        val = q[k].val;
`ifdef ROB_READ_BYPASS_EN
        if (cdb.valid && cdb.tag == a) begin
          v   = 1'b1;
          val = cdb.data;
        end
`endif
      end
    end
  endtask

  task automatic model_check(input string tagname);
    bit          cm, fl, ld, v;
    logic [15:0] rv;
    cm = (q.size() > 0) && q[0].rdy;
    fl = cm && (q[0].op == op_br) && q[0].misp;
    ld = cm && (q[0].op != op_br);
    check({tagname, "_addr"}, 32'(rob_addr), 32'((m_head + q.size()) % 8));
    check({tagname, "_full"}, 32'(rob_full), 32'(q.size() == 8));
    check({tagname, "_ld"},   32'(commit_ld_reg), 32'(ld));
    if (ld) begin
      check({tagname, "_cdest"}, 32'(commit_dest), 32'(q[0].dest));
      check({tagname, "_cval"},  32'(commit_value), 32'(q[0].val));
      check({tagname, "_cent"},  32'(commit_rob_entry), 32'(q[0].tag));
    end
    check({tagname, "_flush"}, 32'(flush), 32'(fl));
    check({tagname, "_fpc"},   32'(flush_pc), fl ? 32'(q[0].val) : 32'd0);
    exp_read(sr1_addr, v, rv);
    check({tagname, "_sr1v"}, 32'(sr1_valid), 32'(v));
    if (v) check({tagname, "_sr1d"}, 32'(sr1_value), 32'(rv));
    exp_read(sr2_addr, v, rv);
    check({tagname, "_sr2v"}, 32'(sr2_valid), 32'(v));
    if (v) check({tagname, "_sr2d"}, 32'(sr2_value), 32'(rv));
  endtask

  // Advance the model across one rising edge with the inputs now applied.
  task automatic model_step();
    bit cm, fl;
    int sz, tl;
    sz = q.size();
    tl = (m_head + sz) % 8;
    cm = (sz > 0) && q[0].rdy;
    fl = cm && (q[0].op == op_br) && q[0].misp;
    if (fl) begin
      q.delete();
      m_head = 0;
      return;
    end
    if (cdb.valid) begin
      foreach (q[k]) begin
        if (q[k].tag == int'(cdb.tag)) begin
          q[k].rdy = 1'b1;
          if (q[k].op == op_br) q[k].misp = cdb.data[0];
          else q[k].val = cdb.data;
        end
      end
    end
    if (cm) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % 8;
    end
    if (rob_write_enable && sz < 8) begin
      q.push_back('{tag: tl, op: rob_opcode, dest: rob_dest, val: rob_value_in,
                    rdy: (rob_opcode == op_lea), misp: 1'b0});
    end
  endtask

  task automatic rand_cycle(input int n);
    lc3b_opcode op;
    int         pend[$];
    logic [2:0] ct;
    logic [15:0] cd;
    @(negedge clk);
    case ($urandom % 8)
      0, 1:    op = op_br;
      2:       op = op_lea;
      3:       op = op_ldr;
      4:       op = op_and;
      default: op = op_add;
    endcase
    foreach (q[k]) if (!q[k].rdy) pend.push_back(q[k].tag);
    ct = 3'($urandom % 8);
    if (pend.size() > 0 && ($urandom % 4) != 0) ct = 3'(pend[$urandom % pend.size()]);
    cd = 16'($urandom);
    cd[0] = (($urandom % 4) == 0);
    drive(($urandom % 100) < 55, op, 3'($urandom), 16'($urandom),
          ($urandom % 2) == 1, ct, cd);
    sr1_addr = 3'($urandom);
    sr2_addr = 3'($urandom);
    #1;
    model_check($sformatf("r%0d", n));
    model_step();
  endtask

  // ---------------- directed vector table -------------------------------
  typedef struct {
    logic we; lc3b_opcode op; logic [2:0] dest; logic [15:0] val;
    logic cv; logic [2:0] ct; logic [15:0] cd;
    logic e_ld; logic [2:0] e_dest; logic [15:0] e_val; logic [2:0] e_ent;
    logic e_flush; logic [15:0] e_pc; logic [2:0] e_addr; logic e_full;
  } vec_t;

  function automatic vec_t mk(logic we, lc3b_opcode op, logic [2:0] dest, logic [15:0] val,
                              logic cv, logic [2:0] ct, logic [15:0] cd,
                              logic e_ld, logic [2:0] e_dest, logic [15:0] e_val,
                              logic [2:0] e_ent, logic e_flush, logic [15:0] e_pc,
                              logic [2:0] e_addr, logic e_full);
    vec_t r;
    r = '{we, op, dest, val, cv, ct, cd, e_ld, e_dest, e_val, e_ent, e_flush, e_pc, e_addr, e_full};
    return r;
  endfunction

  vec_t vecs [23];

  initial begin
    // add d3 -> CDB -> retire; lea retires alone; mispredicted BR flushes an add;
    // out-of-order CDB retires in order; correctly predicted BR retires quietly.
    vecs[0]  = mk(1, op_add, 3, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vecs[1]  = mk(0, op_add, 0, 16'h0000, 1, 0, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    vecs[2]  = mk(0, op_add, 0, 16'h0000, 0, 0, 16'h0000, 1, 3, 16'h1234, 0, 0, 16'h0000, 1, 0);
    vecs[3]  = mk(1, op_lea, 2, 16'h3000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    vecs[4]  = mk(0, op_add, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 16'h3000, 1, 0, 16'h0000, 2, 0);
    vecs[5]  = mk(1, op_br,  0, 16'h0040, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 2, 0);
    vecs[6]  = mk(1, op_add, 4, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0);
    vecs[7]  = mk(0, op_add, 0, 16'h0000, 1, 2, 16'h0001, 0, 0, 16'h0000, 0, 0, 16'h0000, 4, 0);
    vecs[8]  = mk(0, op_add, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0040, 4, 0);
    vecs[9]  = mk(0, op_add, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vecs[10] = mk(0, op_add, 0, 16'h0000, 1, 3, 16'h9999, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vecs[11] = mk(1, op_add, 5, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vecs[12] = mk(1, op_add, 6, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0);
    vecs[13] = mk(0, op_add, 0, 16'h0000, 1, 1, 16'h1111, 0, 0, 16'h0000, 0, 0, 16'h0000, 2, 0);
    vecs[14] = mk(0, op_add, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 2, 0);
    vecs[15] = mk(0, op_add, 0, 16'h0000, 1, 0, 16'h0AAA, 0, 0, 16'h0000, 0, 0, 16'h0000, 2, 0);
    vecs[16] = mk(0, op_add, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 16'h0AAA, 0, 0, 16'h0000, 2, 0);
    vecs[17] = mk(0, op_add, 0, 16'h0000, 0, 0, 16'h0000, 1, 6, 16'h1111, 1, 0, 16'h0000, 2, 0);
    vecs[18] = mk(0, op_add, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 2, 0);
    vecs[19] = mk(1, op_br,  0, 16'h0050, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 2, 0);
    vecs[20] = mk(0, op_add, 0, 16'h0000, 1, 2, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0);
    vecs[21] = mk(0, op_add, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0);
    vecs[22] = mk(0, op_add, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 3, 0);

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].op, vecs[i].dest, vecs[i].val, vecs[i].cv, vecs[i].ct, vecs[i].cd);
      check($sformatf("v%0d_ld", i),    32'(commit_ld_reg), 32'(vecs[i].e_ld));
      if (vecs[i].e_ld) begin
        check($sformatf("v%0d_cdest", i), 32'(commit_dest),      32'(vecs[i].e_dest));
        check($sformatf("v%0d_cval", i),  32'(commit_value),     32'(vecs[i].e_val));
        check($sformatf("v%0d_cent", i),  32'(commit_rob_entry), 32'(vecs[i].e_ent));
      end
      check($sformatf("v%0d_flush", i), 32'(flush),    32'(vecs[i].e_flush));
      check($sformatf("v%0d_fpc", i),   32'(flush_pc), 32'(vecs[i].e_pc));
      check($sformatf("v%0d_addr", i),  32'(rob_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_full", i),  32'(rob_full), 32'(vecs[i].e_full));
    end

    // Fill to capacity, try a 9th write, then prove entry 0 kept its contents.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, op_add, 3'((i + 1) % 8), 16'h0, 0, 0, 16'h0);
      check($sformatf("fill%0d_addr", i), 32'(rob_addr), 32'(i));
      check($sformatf("fill%0d_full", i), 32'(rob_full), 32'd0);
    end
    step(1, op_add, 3'd7, 16'h7777, 0, 0, 16'h0);
    check("full_flag", 32'(rob_full), 32'd1);
    check("full_addr", 32'(rob_addr), 32'd0);
    step(0, op_add, 3'd0, 16'h0, 1, 0, 16'h5555);
    check("full_after9_full", 32'(rob_full), 32'd1);
    check("full_after9_ld",   32'(commit_ld_reg), 32'd0);
    step(0, op_add, 3'd0, 16'h0, 0, 0, 16'h0);
    check("full_commit_ld",   32'(commit_ld_reg), 32'd1);
    check("full_commit_dest", 32'(commit_dest), 32'd1);
    check("full_commit_val",  32'(commit_value), 32'h5555);
    check("full_commit_ent",  32'(commit_rob_entry), 32'd0);

    // Read port behaviour on entry 5 as its result arrives.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, op_add, 3'(i), 16'h0, 0, 0, 16'h0);
    sr1_addr = 3'd5;
    step(0, op_add, 3'd0, 16'h0, 1, 5, 16'hBEEF);
`ifdef ROB_READ_BYPASS_EN
    check("byp_same_valid", 32'(sr1_valid), 32'd1);
    check("byp_same_value", 32'(sr1_value), 32'hBEEF);
`else
    check("nobyp_same_valid", 32'(sr1_valid), 32'd0);
`endif
    step(0, op_add, 3'd0, 16'h0, 0, 0, 16'h0);
    check("rd_next_valid", 32'(sr1_valid), 32'd1);
    check("rd_next_value", 32'(sr1_value), 32'hBEEF);

    // Randomized traffic against the model, with an asynchronous reset midway.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rand_cycle(n);
      if (n == 300) begin
        #1;
        drive(1'b0, op_add, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        reset_n = 1'b0;
        #1;
        check("midrst_addr",  32'(rob_addr), 32'd0);
        check("midrst_full",  32'(rob_full), 32'd0);
        check("midrst_ld",    32'(commit_ld_reg), 32'd0);
        check("midrst_flush", 32'(flush), 32'd0);
        q.delete();
        m_head = 0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
